// File: rtl/muntjac_fpu_sig_div_pkg.sv
// Shared constants and helpers for the significand divider.
//   SigDivWidthMin/Max : legal range of the significand width (hidden bit included)
//   sig_div_cnt_width  : width of the iteration counter that must hold the value Width
package muntjac_fpu_sig_div_pkg;

    localparam int unsigned SigDivWidthMin = 4;
    localparam int unsigned SigDivWidthMax = 64;

    function automatic int unsigned sig_div_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muntjac_fpu_div_step.sv
// One radix-2 restoring division step (purely combinational).
//   rem_i     : partial remainder, Width+1 bits (always < 2*divisor)
//   divisor_i : normalized divisor, Width bits
//   q_o       : quotient bit (rem_i >= divisor_i)
//   rem_o     : next partial remainder, (rem_i - q*divisor) << 1
module muntjac_fpu_div_step
    import muntjac_fpu_sig_div_pkg::*;
#(
    parameter int unsigned Width = 53
) (
    input  logic [Width:0]   rem_i,
    input  logic [Width-1:0] divisor_i,
    output logic             q_o,
    output logic [Width:0]   rem_o
);

    logic [Width:0] diff;

    always_comb begin
        q_o  = rem_i >= {1'b0, divisor_i};
        diff = rem_i - (q_o ? {1'b0, divisor_i} : '0);
        // diff < divisor < 2^Width, so the top bit shifted out is always 0.
        rem_o = diff << 1;
    end

endmodule

// File: rtl/muntjac_fpu_sig_div.sv
// Iterative radix-2 restoring divider for normalized significands.
// Produces Width quotient significand bits plus a round bit and a sticky bit
// for the rounder, and flags when the exponent must be decremented.
//   clk_i, rst_i (sync, active-high), flush_i (abandon operation)
//   req_valid_i/req_ready_o, dividend_i, divisor_i : request (MSBs must be 1)
//   resp_valid_o/resp_ready_i                      : response handshake
//   significand_o : {quotient[Width:1], round, sticky}
//   exp_adjust_o  : 1 when dividend < divisor
// All outputs are registered.
module muntjac_fpu_sig_div
    import muntjac_fpu_sig_div_pkg::*;
#(
    parameter int unsigned Width = 53
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [Width+1:0] significand_o,
    output logic             exp_adjust_o
);

    localparam int unsigned CntW = sig_div_cnt_width(Width);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [Width:0]    rem_q, rem_d;
    logic [Width-1:0]  div_q, div_d;
    logic [Width:0]    quo_q, quo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              exp_q, exp_d;
    logic [Width+1:0]  sig_q, sig_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              accept;

    logic              step_q;
    logic [Width:0]    step_rem;

    muntjac_fpu_div_step #(
        .Width(Width)
    ) u_step (
        .rem_i    (rem_q),
        .divisor_i(div_q),
        .q_o      (step_q),
        .rem_o    (step_rem)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        accept  = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    div_d  = divisor_i;
                    // Pre-shift so the first quotient bit is always 1.
                    if (dividend_i < divisor_i) begin
                        rem_d = {dividend_i, 1'b0};
                        exp_d = 1'b1;
                    end else begin
                        rem_d = {1'b0, dividend_i};
                        exp_d = 1'b0;
                    end
                    quo_d   = '0;
                    cnt_d   = CntW'(Width);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                rem_d = step_rem;
                quo_d = {quo_q[Width-1:0], step_q};
                if (cnt_q == '0) begin
                    // Last (round) bit: capture the response including sticky.
                    sig_d   = {quo_q[Width-1:0], step_q, (step_rem != '0)};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
            accept  = 1'b0;
        end

        ready_d = (state_d == StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            sig_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            assert (dividend_i[Width-1] && divisor_i[Width-1]);
        end
    end

    assign req_ready_o   = ready_q;
    assign resp_valid_o  = valid_q;
    assign significand_o = sig_q;
    assign exp_adjust_o  = exp_q;

endmodule

// File: doc/muntjac_fpu_sig_div.md
# muntjac_fpu_sig_div

Iterative radix-2 restoring divider for normalized significands, sitting directly upstream of the FPU rounding stage. Takes two normalized significands (hidden bit included), produces the normalized quotient significand plus round bit and sticky bit in the exact {lsb, round, sticky} form the rounder consumes, and flags when the quotient exponent must be decremented. Sign, exponent arithmetic and special operands (zero, inf, NaN, subnormal pre-normalization) are handled by the enclosing divide unit.

## Interface
- `Width`, default 53: significand width including hidden bit. Legal range 4..64.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  abandon any operation in flight; no response is produced.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  block can accept a request.
- `dividend_i`  in  Width  dividend significand, MSB must be 1.
- `divisor_i`  in  Width  divisor significand, MSB must be 1.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  consumer accepts result.
- `significand_o`  out  Width+2  [Width+1:2] quotient significand (MSB always 1), [1] round bit, [0] sticky bit.
- `exp_adjust_o`  out  1  1 when dividend < divisor; quotient exponent must be decremented by 1.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset and flush both force IDLE.
- IDLE: `req_ready_o`=1. On `req_valid_i`: latch divisor; if dividend < divisor, load remainder R = dividend<<1 and set exp_adjust, else R = dividend and clear it; clear quotient; load counter = Width; go BUSY.
- R is Width+1 bits; divisor latched Width bits; quotient shift register Width+1 bits.
- BUSY, each cycle: bit q = (R >= divisor); R <= (R − (q ? divisor : 0)) << 1; quotient <= {quotient, q}; counter decrements. When counter is 0 in this cycle, go DONE.
- Exactly Width+1 quotient bits are generated: Width significand bits then one round bit.
- DONE: `resp_valid_o`=1; significand_o = {quotient, (R != 0)}. Holds stable until `resp_ready_i`; then go IDLE.
- `req_ready_o` is 1 only in IDLE; no request is accepted in the DONE→IDLE cycle.
- Non-normalized inputs are illegal: simulation assertion on accept when either MSB is 0; RTL behaviour then unspecified.

## Timing
- Reset values: `req_ready_o`=1, `resp_valid_o`=0, `significand_o`=0, `exp_adjust_o`=0.
- Latency: request accepted at edge T; `resp_valid_o` high after edge T+Width+1 (Width=53: 54 cycles). Fixed, data-independent.
- Throughput: one operation per Width+3 cycles with `resp_ready_i` tied high.
- Output data registered; no combinational path from `req_*` or `resp_ready_i` to any output except none (all outputs are state-decoded).
- `flush_i` has priority over every transition including a same-cycle request accept or response handshake; the cycle after flush is IDLE with `resp_valid_o`=0.
- `rst_i` mid-operation: identical to flush, plus outputs return to reset values.

## Structure
- No new typedefs in `muntjac_fpu_pkg`; FSM enum is local to the module.
- One combinational sub-module is natural: `muntjac_fpu_div_step` (compare, conditional subtract, shift; outputs q bit and next R), to allow a future radix-4 variant by instantiating two.

## Test plan
- Width=4, dividend 4'b1000, divisor 4'b1100 -> after 5 cycles significand_o=6'b101011, exp_adjust_o=1 (1.0101...×2⁻¹, round=1, sticky=1).
- Width=4, dividend 4'b1111, divisor 4'b1000 -> significand_o=6'b111100, exp_adjust_o=0 (exact 1.111).
- Width=4, equal operands 4'b1010 -> significand_o=6'b100000, exp_adjust_o=0; Width=53 random operands vs. reference model, latency exactly 54.
- Hold `resp_ready_i`=0 for 10 cycles in DONE -> outputs stable, `req_ready_o`=0, new requests ignored; release -> IDLE next cycle.
- Assert `flush_i` mid-BUSY and in DONE, also same cycle as `req_valid_i` in IDLE -> no response, IDLE next cycle, next request yields correct result.
- Assert `rst_i` mid-BUSY -> all outputs at reset values next cycle.
